// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The controller drives the start/operand side and the subtractor drives the status/result side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b - bin on one full-subtractor cell; diff/bout/done update WIDTH edges after start is taken.
// No backpressure: start is ignored while shifting, and a start in the done cycle chains straight into the next operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_subtractor_if.slave io
);
  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_next;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_next;
  logic             d;
  logic             bout_q;
  logic             load;
  logic             step;
  logic             finish;

  // The single full-subtractor cell, fed by the current LSBs and the borrow flop.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sd_next = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      if (load) begin
        sa  <= io.a;
        sb  <= io.b;
        br  <= io.bin;
        sd  <= '0;
        cnt <= '0;
      end else if (step) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= br_next;
        sd  <= sd_next;
        cnt <= cnt + CW'(1);
      end
      // Published result holds through the next operation until its last bit lands.
      if (finish) begin
        diff_q <= sd_next;
        bout_q <= br_next;
      end
    end
  end

  assign io.busy = (state_q == SHIFT);
  assign io.done = (state_q == DONE);
  assign io.diff = diff_q;
  assign io.bout = bout_q;
endmodule
